reset_sequencer: RTL and testbench

- Source of the asynchronous resets that feed each domain's reset synchronizer, and the first block out of power-on reset.
- Merges three reset causes into one sequence: PLL lock loss, a debounced push-button, and a software request.
- Holds all downstream stage resets asserted for a minimum width, then releases them one stage at a time.
- Each stage must acknowledge ready before the next is released; a stage that fails to acknowledge raises a fault.

---
 rtl/reset_seq_pkg.sv | 27 ++
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/reset_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types, default parameters and sizing helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      RELEASE,
      WAIT_ACK,
      GAP,
      RUN,
      FAULT
   } state_t;

   localparam int DEF_N_STAGES     = 3;
   localparam int DEF_DEBOUNCE_CYC = 1000000;
   localparam int DEF_HOLD_CYC     = 16;
   localparam int DEF_GAP_CYC      = 8;
   localparam int DEF_ACK_TIMEOUT  = 1024;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Stage-side bundle of the reset sequencer: per-stage resets out, ready acknowledges back, status.
interface reset_sequencer_if #(
   parameter int N_STAGES = 3
);
   localparam int IDX_W = reset_seq_pkg::idx_width(N_STAGES);

   logic [N_STAGES-1:0] stage_rst_n;
   logic [N_STAGES-1:0] stage_ready;
   logic                all_ready;
   logic                fault;
   logic [IDX_W-1:0]    fault_stage;

   modport master (
      output stage_rst_n, all_ready, fault, fault_stage,
      input  stage_ready
   );

   modport slave (
      input  stage_rst_n, all_ready, fault, fault_stage,
      output stage_ready
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop vector synchronizer; output lags input by two clk edges, resets to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_asyn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_asyn) begin
      if (!rst_asyn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// Merges lock loss, debounced button and soft request into a held reset, then releases
// downstream stages one at a time, each gated on its ready acknowledge; all outputs registered.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_STAGES     = DEF_N_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int HOLD_CYC     = DEF_HOLD_CYC,
   parameter int GAP_CYC      = DEF_GAP_CYC,
   parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_asyn,
   input  logic              btn_rst,
   input  logic              pll_locked,
   input  logic              soft_rst_req,
   reset_sequencer_if.master seq_if
);
   localparam int IDX_W  = idx_width(N_STAGES);
   localparam int DEB_W  = cnt_width(DEBOUNCE_CYC);
   localparam int HOLD_W = cnt_width(HOLD_CYC);
   localparam int GAP_W  = cnt_width(GAP_CYC);
   localparam int TO_W   = cnt_width(ACK_TIMEOUT);

   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYC - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_STAGES - 1);

   logic                btn_s;
   logic                locked_s;
   logic [N_STAGES-1:0] ready_s;

   sync_2ff #(.WIDTH(1)) u_btn_sync (
      .clk      (clk),
      .rst_asyn (rst_asyn),
      .d        (btn_rst),
      .q        (btn_s)
   );

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk      (clk),
      .rst_asyn (rst_asyn),
      .d        (pll_locked),
      .q        (locked_s)
   );

   sync_2ff #(.WIDTH(N_STAGES)) u_ready_sync (
      .clk      (clk),
      .rst_asyn (rst_asyn),
      .d        (seq_if.stage_ready),
      .q        (ready_s)
   );

   state_t              state_q, state_d;
   logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_STAGES-1:0] ready_prev_q, ready_prev_d;
   logic [N_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
   logic                all_ready_q, all_ready_d;
   logic                fault_q, fault_d;
   logic [IDX_W-1:0]    fault_stage_q, fault_stage_d;

   logic                btn_pressed;
   logic                cause;
   logic [N_STAGES-1:0] fall;
   logic [IDX_W-1:0]    fall_idx;

   // Saturating debounce: a held button keeps the cause asserted for as long as it is held.
   always_comb begin
      deb_cnt_d = '0;
      if (btn_s) begin
         deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;
      end
   end

   assign btn_pressed = btn_s && (deb_cnt_q == DEB_MAX);
   assign cause       = ~locked_s | btn_pressed | soft_rst_req;
   assign fall        = ready_prev_q & ~ready_s;

   always_comb begin
      fall_idx = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         if (fall[i]) fall_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      to_cnt_d      = to_cnt_q;
      idx_d         = idx_q;
      stage_rst_n_d = stage_rst_n_q;
      fault_d       = fault_q;
      fault_stage_d = fault_stage_q;
      ready_prev_d  = ready_s;

      if (cause) begin
         // A cause overrides any acknowledge or timeout in the same cycle.
         state_d       = HOLD;
         hold_cnt_d    = '0;
         gap_cnt_d     = '0;
         to_cnt_d      = '0;
         idx_d         = '0;
         stage_rst_n_d = '0;
         fault_d       = 1'b0;
         fault_stage_d = '0;
      end else begin
         unique case (state_q)
            HOLD: begin
               stage_rst_n_d = '0;
               if (hold_cnt_q == HOLD_MAX) begin
                  state_d    = RELEASE;
                  hold_cnt_d = '0;
                  idx_d      = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            RELEASE: begin
               stage_rst_n_d[idx_q] = 1'b1;
               to_cnt_d             = '0;
               state_d              = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (ready_s[idx_q]) begin
                  gap_cnt_d = '0;
                  state_d   = (idx_q == IDX_LAST) ? RUN : GAP;
               end else if (to_cnt_q == TO_MAX) begin
                  state_d       = FAULT;
                  stage_rst_n_d = '0;
                  fault_d       = 1'b1;
                  fault_stage_d = idx_q;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_MAX) begin
                  gap_cnt_d = '0;
                  idx_d     = idx_q + 1'b1;
                  state_d   = RELEASE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (|fall) begin
                  state_d       = FAULT;
                  stage_rst_n_d = '0;
                  fault_d       = 1'b1;
                  fault_stage_d = fall_idx;
               end
            end
            FAULT: begin
               stage_rst_n_d = '0;
               fault_d       = 1'b1;
            end
            default: begin
               state_d       = HOLD;
               stage_rst_n_d = '0;
            end
         endcase
      end

      all_ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_asyn) begin
      if (!rst_asyn) begin
         state_q       <= HOLD;
         deb_cnt_q     <= '0;
         hold_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         to_cnt_q      <= '0;
         idx_q         <= '0;
         ready_prev_q  <= '0;
         stage_rst_n_q <= '0;
         all_ready_q   <= 1'b0;
         fault_q       <= 1'b0;
         fault_stage_q <= '0;
      end else begin
         state_q       <= state_d;
         deb_cnt_q     <= deb_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         to_cnt_q      <= to_cnt_d;
         idx_q         <= idx_d;
         ready_prev_q  <= ready_prev_d;
         stage_rst_n_q <= stage_rst_n_d;
         all_ready_q   <= all_ready_d;
         fault_q       <= fault_d;
         fault_stage_q <= fault_stage_d;
      end
   end

   assign seq_if.stage_rst_n = stage_rst_n_q;
   assign seq_if.all_ready   = all_ready_q;
   assign seq_if.fault       = fault_q;
   assign seq_if.fault_stage = fault_stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_STAGES=3, HOLD_CYC=4, GAP_CYC=2, ACK_TIMEOUT=16, DEBOUNCE_CYC=5.
module tb_reset_sequencer;
   logic clk;
   logic rst_asyn;
   logic btn_rst;
   logic pll_locked;
   logic soft_rst_req;

   int n_checks = 0;
   int n_errors = 0;

   reset_sequencer_if #(.N_STAGES(3)) seq_if ();

   reset_sequencer #(
      .N_STAGES     (3),
      .DEBOUNCE_CYC (5),
      .HOLD_CYC     (4),
      .GAP_CYC      (2),
      .ACK_TIMEOUT  (16)
   ) dut (
      .clk          (clk),
      .rst_asyn     (rst_asyn),
      .btn_rst      (btn_rst),
      .pll_locked   (pll_locked),
      .soft_rst_req (soft_rst_req),
      .seq_if       (seq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until stage_rst_n equals val, or -1 if the budget expires.
   task automatic wait_sr(input logic [2:0] val, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (seq_if.stage_rst_n == val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_fault(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (seq_if.fault) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic soft_pulse();
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
   endtask

   initial begin
      int n;
      int bad;

      rst_asyn           = 1'b0;
      btn_rst            = 1'b0;
      pll_locked         = 1'b1;
      soft_rst_req       = 1'b0;
      seq_if.stage_ready = 3'b111;

      // Reset state
      tick();
      tick();
      check_val("rst_stage_rst_n", int'(seq_if.stage_rst_n), 0);
      check_val("rst_all_ready",   int'(seq_if.all_ready),   0);
      check_val("rst_fault",       int'(seq_if.fault),       0);
      check_val("rst_fault_stage", int'(seq_if.fault_stage), 0);

      // Power-up sequence
      rst_asyn = 1'b1;
      wait_sr(3'b001, 30, n);
      check_val("pwr_stage0_edge", n, 7);
      wait_sr(3'b011, 10, n);
      check_val("pwr_stage1_gap", n, 4);
      wait_sr(3'b111, 10, n);
      check_val("pwr_stage2_gap", n, 4);
      check_val("pwr_not_ready_yet", int'(seq_if.all_ready), 0);
      tick();
      check_val("pwr_all_ready", int'(seq_if.all_ready), 1);
      check_val("pwr_fault", int'(seq_if.fault), 0);

      // Short button glitch is ignored
      btn_rst = 1'b1;
      tick(); tick(); tick();
      btn_rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (seq_if.stage_rst_n != 3'b111 || !seq_if.all_ready) bad++;
      end
      check_val("btn_glitch_no_reset", bad, 0);

      // Real 10-cycle press
      btn_rst = 1'b1;
      wait_sr(3'b000, 12, n);
      check_val("btn_press_latency", n, 7);
      check_val("btn_press_all_ready", int'(seq_if.all_ready), 0);
      tick(); tick(); tick();
      btn_rst = 1'b0;
      wait_sr(3'b001, 20, n);
      check_val("btn_release_stage0", n, 7);
      wait_sr(3'b111, 20, n);
      check_val("btn_reseq_stage2", n, 8);
      tick();
      check_val("btn_reseq_all_ready", int'(seq_if.all_ready), 1);

      // Soft request latency, then lock loss while in GAP
      soft_pulse();
      check_val("soft_latency", int'(seq_if.stage_rst_n), 0);
      wait_sr(3'b001, 10, n);
      check_val("soft_stage0", n, 5);
      tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_sr(3'b000, 10, n);
      check_val("lock_loss_latency", (n < 0) ? -1 : n + 1, 3);
      wait_sr(3'b001, 20, n);
      check_val("lock_hold_restart", n, 5);
      wait_sr(3'b011, 10, n);
      check_val("lock_reseq_stage1", n, 4);
      wait_sr(3'b111, 10, n);
      check_val("lock_reseq_stage2", n, 4);
      tick();
      check_val("lock_all_ready", int'(seq_if.all_ready), 1);

      // Ready drop in RUN
      seq_if.stage_ready = 3'b101;
      wait_fault(10, n);
      check_val("drop_fault_edge", n, 3);
      check_val("drop_fault_stage", int'(seq_if.fault_stage), 1);
      check_val("drop_all_ready", int'(seq_if.all_ready), 0);
      check_val("drop_stage_rst_n", int'(seq_if.stage_rst_n), 0);
      tick();
      seq_if.stage_ready = 3'b111;
      for (int i = 0; i < 4; i++) tick();
      check_val("drop_fault_sticky", int'(seq_if.fault), 1);
      soft_pulse();
      check_val("drop_soft_clears_fault", int'(seq_if.fault), 0);
      check_val("drop_soft_clears_stage", int'(seq_if.fault_stage), 0);

      // Acknowledge timeout on stage 1
      seq_if.stage_ready = 3'b101;
      wait_sr(3'b011, 30, n);
      check_val("to_stage1_released", (n > 0) ? 1 : 0, 1);
      wait_fault(30, n);
      check_val("to_fault_edge", n, 16);
      check_val("to_fault_stage", int'(seq_if.fault_stage), 1);
      check_val("to_stage_rst_n", int'(seq_if.stage_rst_n), 0);
      seq_if.stage_ready = 3'b111;
      soft_pulse();
      check_val("to_soft_clears_fault", int'(seq_if.fault), 0);
      wait_sr(3'b111, 30, n);
      check_val("to_reseq_stage2", (n > 0) ? 1 : 0, 1);
      tick();
      check_val("to_reseq_all_ready", int'(seq_if.all_ready), 1);

      // Asynchronous reset while waiting on stage 1
      seq_if.stage_ready = 3'b101;
      soft_pulse();
      wait_sr(3'b011, 30, n);
      check_val("arst_reach_wait", (n > 0) ? 1 : 0, 1);
      tick();
      tick();
      #2;
      rst_asyn = 1'b0;
      #1;
      check_val("arst_stage_rst_n", int'(seq_if.stage_rst_n), 0);
      check_val("arst_all_ready",   int'(seq_if.all_ready),   0);
      check_val("arst_fault",       int'(seq_if.fault),       0);
      check_val("arst_fault_stage", int'(seq_if.fault_stage), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
